// File: rtl/dac8_wb_streamer.sv
// Purpose : Wishbone-slave DAC output path; software pushes 8-bit codes into a
//           FIFO and a programmable sample timer pops one code per period.
// Latency : bus_ack one cycle after accept; pushed code is in the FIFO next cycle;
//           dac_data/dac_ld update on the edge after a timer tick.
// Backpr. : none to the bus (push while full is dropped and flagged overflow);
//           an empty FIFO at a tick holds dac_data and flags underrun.
// Ports   : sys_clk/sys_rst (sync, active-high); bus_* classic Wishbone slave,
//           14-bit byte address with [7:0] decoded; dac_data/dac_ld/dac_ena to the
//           DAC macro; irq = low-water level interrupt.
module dac8_wb_streamer #(
   parameter int DEPTH   = 8,
   parameter int LOWATER = 2
) (
   input  logic        sys_clk,
   input  logic        sys_rst,
   input  logic [13:0] bus_adr,
   input  logic [31:0] bus_dat_w,
   output logic [31:0] bus_dat_r,
   input  logic [3:0]  bus_sel,
   input  logic        bus_cyc,
   input  logic        bus_stb,
   input  logic        bus_we,
   output logic        bus_ack,
   output logic [7:0]  dac_data,
   output logic        dac_ld,
   output logic        dac_ena,
   output logic        irq
);

   localparam int AW = $clog2(DEPTH);
   localparam int LW = AW + 1;
   localparam logic [LW-1:0] DEPTH_L = LW'(DEPTH);

   logic          r_ack;
   logic          r_ena;
   logic          r_lw_ie;
   logic [15:0]   r_rate;
   logic [15:0]   r_cnt;
   logic [7:0]    r_mem [DEPTH];
   logic [AW-1:0] r_wp;
   logic [AW-1:0] r_rp;
   logic [LW-1:0] r_level;
   logic [7:0]    r_dac;
   logic          r_ld;
   logic          r_unr;
   logic          r_ovf;

   logic [7:0] w_adr;
   logic       w_accept, w_wr;
   logic       w_wr_ctrl, w_wr_rate, w_push, w_w1c, w_clr;
   logic       w_ena_nxt, w_tick, w_empty, w_full;
   logic       w_pop, w_push_ok, w_unr_set, w_ovf_set;
   logic       w_unused;

   // The ack register masks the accept term, so each transaction is accepted once.
   assign w_accept  = bus_cyc & bus_stb & ~r_ack;
   assign w_wr      = w_accept & bus_we;
   assign w_adr     = bus_adr[7:0];

   assign w_wr_ctrl = w_wr & (w_adr == 8'h00) & bus_sel[0];
   assign w_wr_rate = w_wr & (w_adr == 8'h04) & (bus_sel[0] | bus_sel[1]);
   assign w_push    = w_wr & (w_adr == 8'h08) & bus_sel[0];
   assign w_w1c     = w_wr & (w_adr == 8'h0C) & bus_sel[2];
   assign w_clr     = w_wr_ctrl & bus_dat_w[1];
   assign w_ena_nxt = w_wr_ctrl ? bus_dat_w[0] : r_ena;

   assign w_tick    = r_ena & (r_cnt == r_rate);
   assign w_empty   = (r_level == '0);
   assign w_full    = (r_level == DEPTH_L);

   // A flush overrides both a pop and a push landing in the same cycle.
   assign w_pop     = w_tick & ~w_empty & ~w_clr;
   assign w_push_ok = w_push & (~w_full | w_pop) & ~w_clr;
   assign w_unr_set = w_tick & w_empty;
   assign w_ovf_set = w_push & w_full & ~w_pop & ~w_clr;

   assign w_unused  = &{1'b0, bus_adr[13:8], bus_dat_w[31:18], bus_sel[3]};

   always_ff @(posedge sys_clk) begin
      if (w_push_ok) begin
         r_mem[r_wp] <= bus_dat_w[7:0];
      end
   end

   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         r_ack   <= 1'b0;
         r_ena   <= 1'b0;
         r_lw_ie <= 1'b0;
         r_rate  <= '0;
         r_cnt   <= '0;
         r_wp    <= '0;
         r_rp    <= '0;
         r_level <= '0;
         r_dac   <= '0;
         r_ld    <= 1'b0;
         r_unr   <= 1'b0;
         r_ovf   <= 1'b0;
      end else begin
         r_ack <= w_accept;

         if (w_wr_ctrl) begin
            r_ena   <= bus_dat_w[0];
            r_lw_ie <= bus_dat_w[2];
         end

         if (w_wr_rate) begin
            if (bus_sel[0]) r_rate[7:0]  <= bus_dat_w[7:0];
            if (bus_sel[1]) r_rate[15:8] <= bus_dat_w[15:8];
         end

         // Counter sits at 0 while disabled and also during the enabling cycle,
         // so the first tick lands RATE_DIV+1 cycles after that accept.
         if (!r_ena || !w_ena_nxt || w_wr_rate || w_tick) begin
            r_cnt <= '0;
         end else begin
            r_cnt <= r_cnt + 16'd1;
         end

         r_ld <= w_pop;
         if (w_pop) begin
            r_dac <= r_mem[r_rp];
         end

         if (w_clr) begin
            r_wp    <= '0;
            r_rp    <= '0;
            r_level <= '0;
         end else begin
            if (w_push_ok) r_wp <= r_wp + AW'(1);
            if (w_pop)     r_rp <= r_rp + AW'(1);
            r_level <= r_level + LW'(w_push_ok) - LW'(w_pop);
         end

         // Set has priority over a same-cycle W1C.
         r_unr <= w_unr_set | (r_unr & ~(w_w1c & bus_dat_w[16]));
         r_ovf <= w_ovf_set | (r_ovf & ~(w_w1c & bus_dat_w[17]));
      end
   end

   always_comb begin
      bus_dat_r = 32'hDEAD_BEEF;
      case (w_adr)
         8'h00:   bus_dat_r = {29'b0, r_lw_ie, 1'b0, r_ena};
         8'h04:   bus_dat_r = {16'b0, r_rate};
         8'h08:   bus_dat_r = {24'b0, r_dac};
         8'h0C:   bus_dat_r = {14'b0, r_ovf, r_unr, 6'b0, w_full, w_empty, 1'b0, 7'(r_level)};
         default: bus_dat_r = 32'hDEAD_BEEF;
      endcase
   end

   assign bus_ack  = r_ack;
   assign dac_data = r_dac;
   assign dac_ld   = r_ld;
   assign dac_ena  = r_ena;
   assign irq      = r_lw_ie & r_ena & ({{(32-LW){1'b0}}, r_level} <= 32'(LOWATER));

endmodule

// File: tb/tb_dac8_wb_streamer.sv
// Purpose : bench for dac8_wb_streamer; queue-based reference model with absolute
//           tick times, directed scenarios plus randomized bus traffic.
// Latency : inputs driven 1 time unit after posedge, outputs sampled there or at negedge.
// Backpr. : every bus wait is bounded; an expired bound is reported as a failure.
module tb_dac8_wb_streamer;

   localparam int DEPTH   = 8;
   localparam int LOWATER = 2;

   logic        sys_clk = 1'b0;
   logic        sys_rst = 1'b1;
   logic [13:0] bus_adr = '0;
   logic [31:0] bus_dat_w = '0;
   logic [31:0] bus_dat_r;
   logic [3:0]  bus_sel = '0;
   logic        bus_cyc = 1'b0, bus_stb = 1'b0, bus_we = 1'b0;
   logic        bus_ack;
   logic [7:0]  dac_data;
   logic        dac_ld, dac_ena, irq;

   int n_chk = 0;
   int n_bad = 0;
   bit mon_en = 1'b0;

   dac8_wb_streamer #(.DEPTH(DEPTH), .LOWATER(LOWATER)) dut (
      .sys_clk(sys_clk), .sys_rst(sys_rst), .bus_adr(bus_adr), .bus_dat_w(bus_dat_w),
      .bus_dat_r(bus_dat_r), .bus_sel(bus_sel), .bus_cyc(bus_cyc), .bus_stb(bus_stb),
      .bus_we(bus_we), .bus_ack(bus_ack), .dac_data(dac_data), .dac_ld(dac_ld),
      .dac_ena(dac_ena), .irq(irq)
   );

   always #5 sys_clk = ~sys_clk;

   // ---------------- reference model ----------------
   logic [7:0]  m_q[$];
   bit          m_ena, m_lwie, m_unr, m_ovf, m_ld, m_ack;
   logic [15:0] m_rate = '0;
   logic [7:0]  m_dac = '0;
   longint      m_cyc = 0;
   longint      m_next = 0;
   logic [7:0]  ld_log[$];

   always @(posedge sys_clk) begin : ref_model
      bit acc, wr, tick, clr, set_u, set_o;
      int a;
      if (sys_rst) begin
         m_q.delete();
         m_ena = 0; m_lwie = 0; m_unr = 0; m_ovf = 0; m_ld = 0; m_ack = 0;
         m_rate = '0; m_dac = '0;
      end else begin
         acc   = bus_cyc && bus_stb && !m_ack;
         wr    = acc && bus_we;
         a     = int'(bus_adr[7:0]);
         tick  = m_ena && (m_cyc == m_next);
         clr   = wr && a == 0 && bus_sel[0] && bus_dat_w[1];
         set_u = 0; set_o = 0; m_ld = 0;
         if (tick) begin
            m_next = m_cyc + longint'(m_rate) + 1;
            if (m_q.size() == 0) set_u = 1;
            else if (!clr) begin
               m_dac = m_q.pop_front();
               m_ld  = 1;
            end
         end
         if (wr && a == 8 && bus_sel[0]) begin
            if (m_q.size() < DEPTH) m_q.push_back(bus_dat_w[7:0]);
            else set_o = 1;
         end
         if (clr) m_q.delete();
         if (wr && a == 12 && bus_sel[2]) begin
            if (bus_dat_w[16]) m_unr = 0;
            if (bus_dat_w[17]) m_ovf = 0;
         end
         if (set_u) m_unr = 1;
         if (set_o) m_ovf = 1;
         if (wr && a == 0 && bus_sel[0]) begin
            if (bus_dat_w[0] && !m_ena) m_next = m_cyc + longint'(m_rate) + 1;
            m_ena  = bus_dat_w[0];
            m_lwie = bus_dat_w[2];
         end
         if (wr && a == 4 && (bus_sel[0] || bus_sel[1])) begin
            if (bus_sel[0]) m_rate[7:0]  = bus_dat_w[7:0];
            if (bus_sel[1]) m_rate[15:8] = bus_dat_w[15:8];
            m_next = m_cyc + longint'(m_rate) + 1;
         end
         m_ack = acc;
      end
      m_cyc++;
   end

   function automatic logic [31:0] model_rd(input logic [13:0] a);
      int lev;
      lev = m_q.size();
      case (a[7:0])
         8'h00:   return {29'b0, m_lwie, 1'b0, m_ena};
         8'h04:   return {16'b0, m_rate};
         8'h08:   return {24'b0, m_dac};
         8'h0C:   return {14'b0, m_ovf, m_unr, 6'b0, lev == DEPTH, lev == 0, 1'b0, 7'(lev)};
         default: return 32'hDEAD_BEEF;
      endcase
   endfunction

   // Continuous cycle-by-cycle comparison of the DAC-side outputs.
   always @(negedge sys_clk) begin
      if (mon_en) begin
         if (dac_ld === 1'b1) ld_log.push_back(dac_data);
         n_chk += 5;
         if (bus_ack !== m_ack) begin n_bad++; $display("FAIL mon_ack t=%0t got=%b want=%b", $time, bus_ack, m_ack); end
         if (dac_ld !== m_ld) begin n_bad++; $display("FAIL mon_ld t=%0t got=%b want=%b", $time, dac_ld, m_ld); end
         if (dac_data !== m_dac) begin n_bad++; $display("FAIL mon_data t=%0t got=%h want=%h", $time, dac_data, m_dac); end
         if (dac_ena !== m_ena) begin n_bad++; $display("FAIL mon_ena t=%0t got=%b want=%b", $time, dac_ena, m_ena); end
         if (irq !== (m_lwie && m_ena && m_q.size() <= LOWATER)) begin
            n_bad++; $display("FAIL mon_irq t=%0t got=%b want=%b", $time, irq, m_lwie && m_ena && m_q.size() <= LOWATER);
         end
      end
   end

   // ---------------- bus tasks ----------------
   task automatic wb_cycle(input bit we, input logic [13:0] a, input logic [31:0] d,
                           input logic [3:0] s, output logic [31:0] rd);
      bit got;
      got = 0;
      rd = 'x;
      bus_cyc = 1; bus_stb = 1; bus_we = we; bus_adr = a; bus_dat_w = d; bus_sel = s;
      for (int i = 0; i < 8 && !got; i++) begin
         @(posedge sys_clk); #1;
         if (bus_ack === 1'b1) begin got = 1; rd = bus_dat_r; end
      end
      bus_cyc = 0; bus_stb = 0; bus_we = 0;
      n_chk++;
      if (!got) begin n_bad++; $display("FAIL wb_ack_timeout adr=%h got no ack want ack within 8 cycles", a); end
   endtask

   task automatic wb_write(input logic [13:0] a, input logic [31:0] d, input logic [3:0] s);
      logic [31:0] dummy;
      wb_cycle(1'b1, a, d, s, dummy);
   endtask

   task automatic wb_read(input logic [13:0] a, output logic [31:0] rd);
      wb_cycle(1'b0, a, 32'h0, 4'hF, rd);
   endtask

   task automatic quiesce();
      wb_write(14'h000, 32'h2, 4'h1);
      wb_write(14'h00C, 32'h0003_0000, 4'h4);
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      logic [31:0] rd;
      logic [31:0] exp_v [4] = '{32'h0, 32'h0, 32'h100, 32'hDEAD_BEEF};
      logic [13:0] adrs  [4] = '{14'h000, 14'h004, 14'h00C, 14'h010};
      sys_rst = 1;
      repeat (3) @(posedge sys_clk);
      #1;
      n_chk++;
      if ({bus_ack, dac_data, dac_ld, dac_ena, irq} !== 12'h0) begin
         n_bad++; $display("FAIL reset_outputs got=%h want=000", {bus_ack, dac_data, dac_ld, dac_ena, irq});
      end
      mon_en = 1;
      sys_rst = 0;
      for (int i = 0; i < 4; i++) begin
         wb_read(adrs[i], rd);
         n_chk++;
         if (rd !== exp_v[i]) begin n_bad++; $display("FAIL reset_read adr=%h got=%h want=%h", adrs[i], rd, exp_v[i]); end
         @(posedge sys_clk); #1;
         n_chk++;
         if (bus_ack !== 1'b0) begin n_bad++; $display("FAIL ack_width adr=%h got=%b want=0", adrs[i], bus_ack); end
      end
   endtask

   task automatic test_stream();
      logic [31:0] rd;
      logic [7:0]  want [3] = '{8'h11, 8'h22, 8'h33};
      logic [7:0]  vals [3];
      int          tms  [3];
      int          nld;
      quiesce();
      wb_write(14'h004, 32'd3, 4'h3);
      for (int i = 0; i < 3; i++) wb_write(14'h008, 32'(want[i]), 4'h1);
      wb_write(14'h000, 32'h1, 4'h1);
      nld = 0;
      for (int i = 2; i <= 21; i++) begin
         @(posedge sys_clk); #1;
         if (dac_ld === 1'b1) begin
            if (nld < 3) begin vals[nld] = dac_data; tms[nld] = i; end
            nld++;
         end
      end
      n_chk++;
      if (nld != 3) begin n_bad++; $display("FAIL stream_count got=%0d want=3", nld); end
      for (int k = 0; k < 3 && k < nld; k++) begin
         n_chk += 2;
         if (vals[k] !== want[k]) begin n_bad++; $display("FAIL stream_value k=%0d got=%h want=%h", k, vals[k], want[k]); end
         if (tms[k] != 5 + 4 * k) begin n_bad++; $display("FAIL stream_time k=%0d got=%0d want=%0d", k, tms[k], 5 + 4 * k); end
      end
      n_chk++;
      if (dac_data !== 8'h33) begin n_bad++; $display("FAIL stream_hold got=%h want=33", dac_data); end
      wb_read(14'h00C, rd);
      n_chk++;
      if (rd !== 32'h0001_0100) begin n_bad++; $display("FAIL stream_underrun got=%h want=00010100", rd); end
      wb_write(14'h000, 32'h0, 4'h1);
      wb_write(14'h00C, 32'h0001_0000, 4'h4);
      wb_read(14'h00C, rd);
      n_chk++;
      if (rd !== 32'h0000_0100) begin n_bad++; $display("FAIL stream_w1c got=%h want=00000100", rd); end
   endtask

   task automatic test_overflow();
      logic [31:0] rd;
      logic [7:0]  codes [DEPTH+1];
      quiesce();
      for (int i = 0; i <= DEPTH; i++) begin
         codes[i] = 8'($urandom);
         wb_write(14'h008, {24'($urandom), codes[i]}, 4'h1);
      end
      wb_read(14'h00C, rd);
      n_chk++;
      if (rd !== (32'(DEPTH) | 32'h0002_0200)) begin
         n_bad++; $display("FAIL ovf_status got=%h want=%h", rd, 32'(DEPTH) | 32'h0002_0200);
      end
      wb_write(14'h004, 32'd0, 4'h3);
      ld_log.delete();
      wb_write(14'h000, 32'h1, 4'h1);
      repeat (12) @(posedge sys_clk);
      #1;
      wb_write(14'h000, 32'h0, 4'h1);
      n_chk++;
      if (ld_log.size() != DEPTH) begin n_bad++; $display("FAIL ovf_drain_count got=%0d want=%0d", ld_log.size(), DEPTH); end
      for (int k = 0; k < DEPTH && k < ld_log.size(); k++) begin
         n_chk++;
         if (ld_log[k] !== codes[k]) begin n_bad++; $display("FAIL ovf_order k=%0d got=%h want=%h", k, ld_log[k], codes[k]); end
      end
   endtask

   task automatic test_push_tick();
      logic [31:0] rd;
      logic [7:0]  p, x;
      p = 8'($urandom); x = 8'($urandom);
      quiesce();
      wb_write(14'h004, 32'd2, 4'h3);
      wb_write(14'h008, 32'(p), 4'h1);
      ld_log.delete();
      wb_write(14'h000, 32'h1, 4'h1);
      repeat (2) @(posedge sys_clk);
      #1;
      wb_write(14'h008, 32'(x), 4'h1);
      wb_read(14'h00C, rd);
      n_chk++;
      if (rd !== 32'h0000_0001) begin n_bad++; $display("FAIL pushtick_level got=%h want=00000001", rd); end
      wb_write(14'h000, 32'h0, 4'h1);
      wb_read(14'h00C, rd);
      n_chk += 2;
      if (rd !== 32'h0000_0100) begin n_bad++; $display("FAIL pushtick_flags got=%h want=00000100", rd); end
      if (ld_log.size() != 2 || ld_log[0] !== p || ld_log[1] !== x) begin
         n_bad++; $display("FAIL pushtick_seq got_n=%0d want p=%h x=%h", ld_log.size(), p, x);
      end
   endtask

   task automatic test_irq();
      bit prev, done;
      int nld;
      quiesce();
      for (int i = 0; i < 4; i++) wb_write(14'h008, $urandom, 4'h1);
      wb_write(14'h004, 32'd3, 4'h3);
      wb_write(14'h000, 32'h5, 4'h1);
      n_chk++;
      if (irq !== 1'b0) begin n_bad++; $display("FAIL irq_level4 got=%b want=0", irq); end
      prev = irq; nld = 0; done = 0;
      for (int i = 0; i < 30 && !done; i++) begin
         @(posedge sys_clk); #1;
         if (dac_ld === 1'b1) nld++;
         if (nld == 2) begin
            done = 1;
            n_chk++;
            if (irq !== 1'b1 || prev !== 1'b0) begin
               n_bad++; $display("FAIL irq_rise got=%b prev=%b want=1 prev=0", irq, prev);
            end
         end
         prev = irq;
      end
      n_chk++;
      if (!done) begin n_bad++; $display("FAIL irq_timeout got pops=%0d want 2", nld); end
      wb_write(14'h008, $urandom, 4'h1);
      n_chk++;
      if (irq !== 1'b0) begin n_bad++; $display("FAIL irq_fall got=%b want=0", irq); end
      wb_write(14'h000, 32'h0, 4'h1);
   endtask

   task automatic test_clr();
      logic [31:0] rd;
      quiesce();
      wb_write(14'h004, 32'd7, 4'h3);
      for (int i = 0; i < 5; i++) wb_write(14'h008, $urandom, 4'h1);
      wb_write(14'h000, 32'h1, 4'h1);
      repeat (7) @(posedge sys_clk);
      #1;
      ld_log.delete();
      wb_write(14'h000, 32'h3, 4'h1);
      n_chk++;
      if (dac_ld !== 1'b0) begin n_bad++; $display("FAIL clr_no_ld got=%b want=0", dac_ld); end
      wb_read(14'h00C, rd);
      n_chk++;
      if (rd !== 32'h0000_0100) begin n_bad++; $display("FAIL clr_level got=%h want=00000100", rd); end
      repeat (8) @(posedge sys_clk);
      #1;
      wb_read(14'h00C, rd);
      n_chk += 2;
      if (rd !== 32'h0001_0100) begin n_bad++; $display("FAIL clr_underrun got=%h want=00010100", rd); end
      if (ld_log.size() != 0) begin n_bad++; $display("FAIL clr_ld_count got=%0d want=0", ld_log.size()); end
      wb_write(14'h000, 32'h0, 4'h1);
   endtask

   task automatic test_random();
      logic [31:0] rd, ex;
      logic [13:0] a;
      logic [3:0]  s;
      int          op;
      for (int n = 0; n < 250; n++) begin
         op = $urandom_range(0, 9);
         s  = 4'($urandom);
         case (op)
            0, 1, 2: wb_write(14'h008, $urandom, 4'hF);
            3:       wb_write(14'h008, $urandom, s);
            4:       wb_write(14'h004, 32'($urandom_range(0, 6)), s);
            5:       wb_write(14'h000, 32'($urandom_range(0, 7)), s);
            6:       wb_write(14'h00C, {14'b0, 2'($urandom), 16'h0}, s);
            7, 8: begin
               case ($urandom_range(0, 4))
                  0: a = 14'h000;
                  1: a = 14'h004;
                  2: a = 14'h008;
                  3: a = 14'h00C;
                  default: a = 14'($urandom);
               endcase
               wb_read(a, rd);
               ex = model_rd(a);
               n_chk++;
               if (rd !== ex) begin n_bad++; $display("FAIL rand_read adr=%h got=%h want=%h", a, rd, ex); end
            end
            default: begin
               repeat ($urandom_range(0, 5)) @(posedge sys_clk);
               #1;
            end
         endcase
      end
      quiesce();
   endtask

   initial begin
      #2_000_000;
      $display("FAIL global_timeout got no finish want finish");
      $fatal(1);
   end

   initial begin
      test_reset();
      test_stream();
      test_overflow();
      test_push_tick();
      test_irq();
      test_clr();
      test_random();
      repeat (2) @(posedge sys_clk);
      #1;
      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end

endmodule
